// File: rtl/feature_load_engine_if.sv
// Memory read channel plus feature buffer write port of the feature load engine.
// master = engine side, slave = memory controller / feature buffer side.
interface feature_load_engine_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 512
);
    logic                      mem_rd_req;
    logic [ADDR_WIDTH-1:0]     mem_rd_addr;
    logic [4:0]                mem_rd_len;
    logic                      mem_rd_req_ready;
    logic [MEM_DATA_WIDTH-1:0] mem_rd_data;
    logic                      mem_rd_data_valid;

    logic [MEM_DATA_WIDTH-1:0] feature_data;
    logic                      feature_buffer_1_valid;
    logic                      feature_buffer_2_valid;
    logic                      feature_buffer_1_ready;
    logic                      feature_buffer_2_ready;

    modport master (
        output mem_rd_req, mem_rd_addr, mem_rd_len,
        input  mem_rd_req_ready, mem_rd_data, mem_rd_data_valid,
        output feature_data, feature_buffer_1_valid, feature_buffer_2_valid,
        input  feature_buffer_1_ready, feature_buffer_2_ready
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, mem_rd_len,
        output mem_rd_req_ready, mem_rd_data, mem_rd_data_valid,
        input  feature_data, feature_buffer_1_valid, feature_buffer_2_valid,
        output feature_buffer_1_ready, feature_buffer_2_ready
    );
endinterface

// File: rtl/feature_load_engine.sv
// Loads one or two input-channel patches from memory into the feature buffers in bounded bursts.
// Latency: first read request 3 cycles after load_start; each returned beat reaches the buffer 1 cycle later.
// Backpressure: a request is raised only when the target buffer is ready; returned beats are never stalled.
module feature_load_engine #(
    parameter int FEATURE_WIDTH  = 16,
    parameter int MEM_DATA_WIDTH = 32 * FEATURE_WIDTH,
    parameter int ADDR_WIDTH     = 32,
    parameter int BURST_MAX      = 16
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] patch_stride,
    input  logic [9:0]            row_size,
    input  logic [9:0]            col_size,
    input  logic                  feature_double_patch,
    output logic                  load_busy,
    output logic                  load_finish,
    output logic                  load_feature_begin,
    feature_load_engine_if.master bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, CALC, REQ, DATA, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]     base_q, stride_q, addr1, addr2, addr_cur;
    logic [9:0]                row_q, col_q;
    logic                      dbl_q;
    logic [19:0]               area;
    logic [18:0]               words;
    logic [18:0]               rem1, rem2, rem_cur, rem1_upd, rem2_upd, other_rem;
    logic [4:0]                beat_cnt, req_len;
    logic                      cur2, cur2_nx;
    logic                      req_q, req_nx, buf_rdy_nx;
    logic                      accept, beat, last_beat;
    logic [MEM_DATA_WIDTH-1:0] data_q;
    logic                      fb1_vld_q, fb2_vld_q;

    // Words per patch: 4 pixels per memory word, rounded up.
    assign area  = 20'(row_q) * 20'(col_q);
    assign words = 19'(({1'b0, area} + 21'd3) >> 2);

    assign rem_cur   = cur2 ? rem2 : rem1;
    assign addr_cur  = cur2 ? addr2 : addr1;
    assign req_len   = (rem_cur > 19'(BURST_MAX)) ? 5'(BURST_MAX) : rem_cur[4:0];
    assign accept    = req_q & bus.mem_rd_req_ready;
    assign beat      = (state == DATA) & bus.mem_rd_data_valid;
    assign last_beat = beat & (beat_cnt == 5'd1);
    assign rem1_upd  = (beat & ~cur2) ? rem1 - 19'd1 : rem1;
    assign rem2_upd  = (beat &  cur2) ? rem2 - 19'd1 : rem2;
    assign other_rem = cur2 ? rem1_upd : rem2_upd;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cur2_nx  = cur2;
        case (state)
            IDLE:  if (load_start) state_nx = CLEAR;
            CLEAR: state_nx = CALC;
            CALC: begin
                cur2_nx  = 1'b0;
                state_nx = (words == '0) ? DONE : REQ;
            end
            REQ:   if (accept) state_nx = DATA;
            DATA: begin
                if (last_beat) begin
                    if (rem1_upd == '0 && rem2_upd == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = REQ;
                        // Alternate patches so both buffers fill together.
                        if (dbl_q && other_rem != '0) cur2_nx = ~cur2;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Buffer ready gates only the rising of a request; an issued request is held until taken.
        buf_rdy_nx = cur2_nx ? bus.feature_buffer_2_ready : bus.feature_buffer_1_ready;
        req_nx     = (state_nx == REQ) && ((req_q && !accept) || buf_rdy_nx);
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            stride_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            dbl_q     <= 1'b0;
            addr1     <= '0;
            addr2     <= '0;
            rem1      <= '0;
            rem2      <= '0;
            beat_cnt  <= '0;
            cur2      <= 1'b0;
            req_q     <= 1'b0;
            data_q    <= '0;
            fb1_vld_q <= 1'b0;
            fb2_vld_q <= 1'b0;
        end else begin
            req_q     <= req_nx;
            cur2      <= cur2_nx;
            fb1_vld_q <= beat & ~cur2;
            fb2_vld_q <= beat &  cur2;

            if (state == IDLE && load_start) begin
                base_q   <= base_addr;
                stride_q <= patch_stride;
                row_q    <= row_size;
                col_q    <= col_size;
                dbl_q    <= feature_double_patch;
            end

            if (state == CALC) begin
                rem1  <= words;
                rem2  <= dbl_q ? words : '0;
                addr1 <= base_q;
                addr2 <= base_q + stride_q;
            end

            if (accept) begin
                beat_cnt <= req_len;
                if (cur2) begin
                    addr2 <= addr2 + {{(ADDR_WIDTH-5){1'b0}}, req_len};
                end else begin
                    addr1 <= addr1 + {{(ADDR_WIDTH-5){1'b0}}, req_len};
                end
            end

            if (beat) begin
                beat_cnt <= beat_cnt - 5'd1;
                rem1     <= rem1_upd;
                rem2     <= rem2_upd;
                data_q   <= bus.mem_rd_data;
            end
        end
    end

    assign load_busy              = (state != IDLE);
    assign load_feature_begin     = (state == CLEAR);
    assign load_finish            = (state == DONE);
    assign bus.mem_rd_req         = req_q;
    assign bus.mem_rd_addr        = addr_cur;
    assign bus.mem_rd_len         = req_len;
    assign bus.feature_data       = data_q;
    assign bus.feature_buffer_1_valid = fb1_vld_q;
    assign bus.feature_buffer_2_valid = fb2_vld_q;

endmodule

// File: tb/tb_feature_load_engine.sv
// Bench for feature_load_engine: directed timing sequences, a table of loads, and randomized loads
// checked against a burst/beat model built from the load parameters.
module tb_feature_load_engine;
    localparam int AW = 32;
    localparam int DW = 512;

    logic          system_clk = 1'b0;
    logic          rst_n      = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] base_addr  = '0;
    logic [AW-1:0] patch_stride = '0;
    logic [9:0]    row_size   = '0;
    logic [9:0]    col_size   = '0;
    logic          feature_double_patch = 1'b0;
    logic          load_busy, load_finish, load_feature_begin;

    always #5 system_clk = ~system_clk;

    feature_load_engine_if #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus ();

    feature_load_engine #(
        .FEATURE_WIDTH (16),
        .MEM_DATA_WIDTH(DW),
        .ADDR_WIDTH    (AW),
        .BURST_MAX     (16)
    ) dut (
        .system_clk          (system_clk),
        .rst_n               (rst_n),
        .load_start          (load_start),
        .base_addr           (base_addr),
        .patch_stride        (patch_stride),
        .row_size            (row_size),
        .col_size            (col_size),
        .feature_double_patch(feature_double_patch),
        .load_busy           (load_busy),
        .load_finish         (load_finish),
        .load_feature_begin  (load_feature_begin),
        .bus                 (bus)
    );

    typedef struct { logic [AW-1:0] addr; int len; int patch; } req_t;
    typedef struct { int patch; logic [DW-1:0] data; } beat_t;
    typedef struct {
        logic [9:0] row; logic [9:0] col; logic dbl;
        logic [AW-1:0] base; logic [AW-1:0] stride;
        int exp_strobes; int exp_reqs; bit rnd; bit poke;
    } vec_t;

    req_t  exp_req_q[$];
    beat_t pend_q[$];
    beat_t exp_beat_q[$];
    req_t  cur_req;
    bit    req_seen, finished, poke_armed, rnd_mode;
    int    exp_words_total, n_str, n_req, beats_driven;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "/busy"},   64'(load_busy), 64'd0);
        check({tag, "/finish"}, 64'(load_finish), 64'd0);
        check({tag, "/begin"},  64'(load_feature_begin), 64'd0);
        check({tag, "/req"},    64'(bus.mem_rd_req), 64'd0);
        check({tag, "/addr"},   64'(bus.mem_rd_addr), 64'd0);
        check({tag, "/len"},    64'(bus.mem_rd_len), 64'd0);
        check({tag, "/strobe"}, 64'({bus.feature_buffer_2_valid, bus.feature_buffer_1_valid}), 64'd0);
        check({tag, "/data"},   64'(bus.feature_data == '0), 64'd1);
    endtask

    // Expected bursts: patch words split into 16-beat chunks, patch 1 and patch 2 chunks interleaved.
    task automatic build_model(input logic [9:0] r, input logic [9:0] c, input logic d,
                               input logic [AW-1:0] b, input logic [AW-1:0] s);
        int w, nb, len;
        logic [AW-1:0] off;
        exp_req_q.delete(); pend_q.delete(); exp_beat_q.delete();
        w  = (int'(r) * int'(c) + 3) / 4;
        nb = (w + 15) / 16;
        exp_words_total = d ? 2 * w : w;
        for (int i = 0; i < nb; i++) begin
            len = (w - 16 * i < 16) ? w - 16 * i : 16;
            off = AW'(16 * i);
            exp_req_q.push_back('{b + off, len, 1});
            if (d) exp_req_q.push_back('{b + s + off, len, 2});
        end
        req_seen = 0; n_str = 0; n_req = 0; beats_driven = 0; finished = 0;
    endtask

    task automatic start_load(input logic [9:0] r, input logic [9:0] c, input logic d,
                              input logic [AW-1:0] b, input logic [AW-1:0] s);
        build_model(r, c, d, b, s);
        row_size = r; col_size = c; feature_double_patch = d;
        base_addr = b; patch_stride = s;
        load_start = 1'b1;
        @(negedge system_clk);
        load_start = 1'b0;
        check("clear_pulse", 64'(load_feature_begin), 64'd1);
    endtask

    task automatic accept_burst();
        beat_t bt;
        for (int i = 0; i < cur_req.len; i++) begin
            bt.patch = cur_req.patch;
            bt.data  = rand_beat();
            pend_q.push_back(bt);
        end
        req_seen = 0;
    endtask

    task automatic drive(input bit poke);
        beat_t bt;
        load_start = 1'b0;
        if (poke && poke_armed && beats_driven == 3) begin
            load_start = 1'b1;
            row_size = 10'd7; col_size = 10'd3; feature_double_patch = 1'b1;
            base_addr = 32'hDEAD_0000;
            poke_armed = 0;
        end
        bus.mem_rd_data_valid = 1'b0;
        bus.mem_rd_data = rand_beat();
        if (pend_q.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
            bt = pend_q.pop_front();
            bus.mem_rd_data = bt.data;
            bus.mem_rd_data_valid = 1'b1;
            exp_beat_q.push_back(bt);
            beats_driven++;
        end
        if (rnd_mode) begin
            bus.feature_buffer_1_ready = ($urandom_range(0, 3) != 0);
            bus.feature_buffer_2_ready = ($urandom_range(0, 3) != 0);
            bus.mem_rd_req_ready       = ($urandom_range(0, 2) != 0);
        end else begin
            bus.feature_buffer_1_ready = 1'b1;
            bus.feature_buffer_2_ready = 1'b1;
            bus.mem_rd_req_ready       = 1'b1;
        end
        if (bus.mem_rd_req && bus.mem_rd_req_ready) accept_burst();
    endtask

    task automatic observe();
        beat_t e;
        logic  strobe;
        strobe = bus.feature_buffer_1_valid | bus.feature_buffer_2_valid;
        if (strobe) begin
            n_str++;
            if (exp_beat_q.size() == 0) begin
                check("unexpected_strobe", 64'(strobe), 64'd0);
            end else begin
                e = exp_beat_q.pop_front();
                check("strobe_patch", 64'({bus.feature_buffer_2_valid, bus.feature_buffer_1_valid}),
                      (e.patch == 2) ? 64'd2 : 64'd1);
                check("feature_data", 64'(bus.feature_data == e.data), 64'd1);
            end
        end
        if (bus.mem_rd_req) begin
            if (!req_seen) begin
                n_req++;
                req_seen = 1;
                if (exp_req_q.size() == 0) check("unexpected_req", 64'(bus.mem_rd_req), 64'd0);
                else cur_req = exp_req_q.pop_front();
            end
            check("req_addr", 64'(bus.mem_rd_addr), 64'(cur_req.addr));
            check("req_len",  64'(bus.mem_rd_len),  64'(cur_req.len));
        end
        if (load_finish) begin
            finished = 1;
            check("finish_on_last_strobe", 64'(strobe), 64'(exp_words_total != 0));
            check("beats_outstanding", 64'(exp_beat_q.size() + pend_q.size()), 64'd0);
            check("reqs_outstanding", 64'(exp_req_q.size()), 64'd0);
        end else begin
            check("busy", 64'(load_busy), 64'd1);
        end
    endtask

    task automatic service(input bit poke);
        int cyc;
        cyc = 0;
        poke_armed = poke;
        while (!finished && cyc < 20000) begin
            drive(poke);
            @(negedge system_clk);
            observe();
            cyc++;
        end
        check("load_completed", 64'(finished), 64'd1);
        drive(1'b0);
        @(negedge system_clk);
        check("idle_after_finish", 64'(load_busy), 64'd0);
    endtask

    vec_t tbl[11];

    initial begin
        logic [9:0]    rr, rc;
        logic          rd;
        logic [AW-1:0] rb, rs;
        int            cyc;

        tbl[0]  = '{10'd8,    10'd8,  1'b0, 32'h0000_0100, 32'h0,     16,  1, 1'b0, 1'b0};
        tbl[1]  = '{10'd10,   10'd10, 1'b0, 32'h0000_0100, 32'h0,     25,  2, 1'b0, 1'b1};
        tbl[2]  = '{10'd4,    10'd4,  1'b1, 32'h0000_0100, 32'h400,    8,  2, 1'b0, 1'b0};
        tbl[3]  = '{10'd0,    10'd5,  1'b1, 32'h0000_0100, 32'h400,    0,  0, 1'b0, 1'b0};
        tbl[4]  = '{10'd1,    10'd1,  1'b0, 32'h0000_0040, 32'h0,      1,  1, 1'b0, 1'b0};
        tbl[5]  = '{10'd7,    10'd9,  1'b1, 32'hFFFF_FF00, 32'h200,   32,  2, 1'b0, 1'b0};
        tbl[6]  = '{10'd10,   10'd10, 1'b0, 32'hFFFF_FFF8, 32'h0,     25,  2, 1'b0, 1'b0};
        tbl[7]  = '{10'd5,    10'd7,  1'b1, 32'h0000_0040, 32'h1000,  18,  2, 1'b0, 1'b0};
        tbl[8]  = '{10'd1023, 10'd3,  1'b0, 32'h0001_0000, 32'h0,    768, 48, 1'b1, 1'b0};
        tbl[9]  = '{10'd33,   10'd17, 1'b1, 32'h0002_0000, 32'h800,  282, 18, 1'b1, 1'b0};
        tbl[10] = '{10'd20,   10'd20, 1'b1, 32'h0003_0000, 32'h1000, 200, 14, 1'b1, 1'b1};

        bus.mem_rd_req_ready       = 1'b0;
        bus.mem_rd_data            = '0;
        bus.mem_rd_data_valid      = 1'b0;
        bus.feature_buffer_1_ready = 1'b1;
        bus.feature_buffer_2_ready = 1'b1;
        rnd_mode = 0;

        #3;
        check_all_zero("reset");
        @(negedge system_clk);
        rst_n = 1'b1;
        @(negedge system_clk);

        // Empty feature map: clear, calc, done with no request.
        build_model(10'd0, 10'd5, 1'b0, 32'h100, 32'h0);
        row_size = 10'd0; col_size = 10'd5; feature_double_patch = 1'b0;
        load_start = 1'b1;
        @(negedge system_clk);
        load_start = 1'b0;
        check("empty/begin_n1",  64'(load_feature_begin), 64'd1);
        check("empty/busy_n1",   64'(load_busy), 64'd1);
        @(negedge system_clk);
        check("empty/begin_n2",  64'(load_feature_begin), 64'd0);
        check("empty/finish_n2", 64'(load_finish), 64'd0);
        check("empty/req_n2",    64'(bus.mem_rd_req), 64'd0);
        @(negedge system_clk);
        check("empty/finish_n3", 64'(load_finish), 64'd1);
        check("empty/req_n3",    64'(bus.mem_rd_req), 64'd0);
        @(negedge system_clk);
        check("empty/finish_n4", 64'(load_finish), 64'd0);
        check("empty/busy_n4",   64'(load_busy), 64'd0);

        for (int i = 0; i < 11; i++) begin
            rnd_mode = tbl[i].rnd;
            start_load(tbl[i].row, tbl[i].col, tbl[i].dbl, tbl[i].base, tbl[i].stride);
            service(tbl[i].poke);
            check($sformatf("tbl%0d/strobes", i), 64'(n_str), 64'(tbl[i].exp_strobes));
            check($sformatf("tbl%0d/reqs", i),    64'(n_req), 64'(tbl[i].exp_reqs));
        end

        // Buffer not ready: request waits, then holds while the memory stalls.
        rnd_mode = 0;
        bus.feature_buffer_1_ready = 1'b0;
        bus.mem_rd_req_ready = 1'b0;
        start_load(10'd8, 10'd8, 1'b0, 32'h200, 32'h0);
        @(negedge system_clk);
        check("rdy/calc_no_req", 64'(bus.mem_rd_req), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge system_clk);
            check("rdy/req_waits", 64'(bus.mem_rd_req), 64'd0);
        end
        bus.feature_buffer_1_ready = 1'b1;
        @(negedge system_clk);
        check("rdy/req_rises", 64'(bus.mem_rd_req), 64'd1);
        check("rdy/addr", 64'(bus.mem_rd_addr), 64'h200);
        check("rdy/len",  64'(bus.mem_rd_len), 64'd16);
        bus.feature_buffer_1_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge system_clk);
            check("rdy/req_held",  64'(bus.mem_rd_req), 64'd1);
            check("rdy/addr_held", 64'(bus.mem_rd_addr), 64'h200);
            check("rdy/len_held",  64'(bus.mem_rd_len), 64'd16);
        end
        cur_req = exp_req_q.pop_front();
        req_seen = 1;
        bus.mem_rd_req_ready = 1'b1;
        accept_burst();
        @(negedge system_clk);
        check("rdy/req_drops", 64'(bus.mem_rd_req), 64'd0);
        service(1'b0);
        check("rdy/strobes", 64'(n_str), 64'd16);

        // Reset during the third beat of a burst.
        rnd_mode = 0;
        start_load(10'd8, 10'd8, 1'b0, 32'h300, 32'h0);
        cyc = 0;
        while (beats_driven < 2 && cyc < 200) begin
            drive(1'b0);
            @(negedge system_clk);
            observe();
            cyc++;
        end
        check("rst/two_beats_seen", 64'(n_str), 64'd2);
        drive(1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_burst");
        @(negedge system_clk);
        rst_n = 1'b1;
        pend_q.delete(); exp_beat_q.delete();
        for (int i = 0; i < 13; i++) begin
            bus.mem_rd_data = rand_beat();
            bus.mem_rd_data_valid = 1'b1;
            @(negedge system_clk);
            check("rst/no_strobe", 64'({bus.feature_buffer_2_valid, bus.feature_buffer_1_valid}), 64'd0);
            check("rst/idle", 64'(load_busy), 64'd0);
        end
        bus.mem_rd_data_valid = 1'b0;
        start_load(10'd8, 10'd8, 1'b0, 32'h100, 32'h0);
        service(1'b0);
        check("rst/reload_strobes", 64'(n_str), 64'd16);
        check("rst/reload_reqs", 64'(n_req), 64'd1);

        // Randomized loads with random stalls on every handshake.
        for (int k = 0; k < 8; k++) begin
            rr = 10'($urandom_range(0, 30));
            rc = 10'($urandom_range(1, 30));
            rd = 1'($urandom_range(0, 1));
            rb = $urandom();
            rs = $urandom();
            rnd_mode = 1;
            start_load(rr, rc, rd, rb, rs);
            service(1'($urandom_range(0, 1)));
            check("rand/strobes", 64'(n_str), 64'(exp_words_total));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
